proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_control_if.sv | 23 ++
 rtl/proc_control.sv | 97 +++++++++
 tb/tb_proc_control.sv | 128 ++++++++++++
 3 files changed

// File: rtl/proc_control_if.sv
// Control-bus bundle between the step controller and its datapath/driver.
// The controller side is 'master'; the side supplying run/din is 'slave'.
interface proc_control_if;
  logic        run;
  logic [15:0] din;
  logic [15:0] ir_out;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic        addsub;
  logic        done;

  modport master (
    input  run, din,
    output ir_out, sel, r_in, a_in, g_in, addsub, done
  );

  modport slave (
    output run, din,
    input  ir_out, sel, r_in, a_in, g_in, addsub, done
  );
endinterface

// File: rtl/proc_control.sv
// Four-step instruction controller for a simple 8-register processor datapath.
// State and IR are registered; every control output is decoded from them.
module proc_control #(
  parameter logic [2:0] OP_MV  = 3'b000,
  parameter logic [2:0] OP_MVT = 3'b001,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SUB = 3'b011
) (
  input  logic            clk,
  input  logic            resetn,
  proc_control_if.master  bus
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [3:0] SEL_IMM = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  step_t       state;
  logic [15:0] ir;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       imm;
  logic       is_arith;

  assign op       = ir[15:13];
  assign rx       = ir[12:10];
  assign imm      = ir[9];
  assign ry       = ir[2:0];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= 16'h0000;
    end else begin
      case (state)
        T0: if (bus.run) begin
              ir    <= bus.din;
              state <= T1;
            end
        T1:      state <= is_arith ? T2 : T0;
        T2:      state <= is_arith ? T3 : T0;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.sel    = 4'd0;
    bus.r_in   = 8'h00;
    bus.a_in   = 1'b0;
    bus.g_in   = 1'b0;
    bus.addsub = 1'b0;
    bus.done   = 1'b0;
    case (state)
      T1: begin
        if (op == OP_MV) begin
          bus.sel  = imm ? SEL_IMM : {1'b0, ry};
          bus.r_in = 8'(1) << rx;
          bus.done = 1'b1;
        end else if (op == OP_MVT) begin
          bus.sel  = SEL_IMM;
          bus.r_in = 8'(1) << rx;
          bus.done = 1'b1;
        end else if (is_arith) begin
          bus.sel  = {1'b0, rx};
          bus.a_in = 1'b1;
        end else begin
          // Undefined opcodes retire as a no-op.
          bus.done = 1'b1;
        end
      end
      T2: if (is_arith) begin
        bus.sel    = imm ? SEL_IMM : {1'b0, ry};
        bus.g_in   = 1'b1;
        bus.addsub = (op == OP_SUB);
      end
      T3: if (is_arith) begin
        bus.sel  = SEL_G;
        bus.r_in = 8'(1) << rx;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir_out = ir;

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: the stimulus queues the expected outputs
// of each cycle and a negedge monitor pops and compares them.
module tb_proc_control;

  logic clk;
  logic resetn;

  proc_control_if bus ();

  proc_control dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        addsub;
    logic        done;
    logic [15:0] ir;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input logic [3:0] s, input logic [7:0] ri,
                              input logic a, input logic g, input logic as_,
                              input logic dn, input logic [15:0] ir);
    exp_t e;
    e.name = n; e.sel = s; e.r_in = ri; e.a_in = a; e.g_in = g;
    e.addsub = as_; e.done = dn; e.ir = ir;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (sel,r_in,a,g,addsub,done,ir_out)", name, act, exp);
    end
  endtask

  // One cycle: apply inputs just after the edge and queue this cycle's outputs.
  task automatic step(input logic rn, input logic r, input logic [15:0] d, input exp_t e);
    @(posedge clk);
    #1;
    resetn  = rn;
    bus.run = r;
    bus.din = d;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name,
              {bus.sel, bus.r_in, bus.a_in, bus.g_in, bus.addsub, bus.done, bus.ir_out},
              {e.sel, e.r_in, e.a_in, e.g_in, e.addsub, e.done, e.ir});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    resetn  = 1'b0;
    bus.run = 1'b0;
    bus.din = 16'h0000;

    //   resetn run  din       name          sel   r_in   a  g  as dn ir
    step(1'b0, 1'b1, 16'h0A05, mk("reset",      4'd0, 8'h00, 0, 0, 0, 0, 16'h0000));
    step(1'b1, 1'b1, 16'h0A05, mk("first_load", 4'd0, 8'h00, 0, 0, 0, 0, 16'h0000));
    // mv R2,#5
    step(1'b1, 1'b0, 16'h0000, mk("mv_t1",      4'd8, 8'h04, 0, 0, 0, 1, 16'h0A05));
    step(1'b1, 1'b0, 16'h1234, mk("mv_idle",    4'd0, 8'h00, 0, 0, 0, 0, 16'h0A05));
    // add R1,R3 with run/din toggling during T1/T2 (must be ignored)
    step(1'b1, 1'b1, 16'h4403, mk("add_t0",     4'd0, 8'h00, 0, 0, 0, 0, 16'h0A05));
    step(1'b1, 1'b1, 16'hFFFF, mk("add_t1",     4'd1, 8'h00, 1, 0, 0, 0, 16'h4403));
    step(1'b1, 1'b1, 16'hFFFF, mk("add_t2",     4'd3, 8'h00, 0, 1, 0, 0, 16'h4403));
    step(1'b1, 1'b0, 16'hFFFF, mk("add_t3",     4'd9, 8'h02, 0, 0, 0, 1, 16'h4403));
    // sub R0,#1
    step(1'b1, 1'b1, 16'h6201, mk("sub_t0",     4'd0, 8'h00, 0, 0, 0, 0, 16'h4403));
    step(1'b1, 1'b0, 16'h0000, mk("sub_t1",     4'd0, 8'h00, 1, 0, 0, 0, 16'h6201));
    step(1'b1, 1'b0, 16'h0000, mk("sub_t2",     4'd8, 8'h00, 0, 1, 1, 0, 16'h6201));
    step(1'b1, 1'b0, 16'h0000, mk("sub_t3",     4'd9, 8'h01, 0, 0, 0, 1, 16'h6201));
    // mvt R7,#8'hAB
    step(1'b1, 1'b1, 16'h3CAB, mk("mvt_t0",     4'd0, 8'h00, 0, 0, 0, 0, 16'h6201));
    step(1'b1, 1'b0, 16'h0000, mk("mvt_t1",     4'd8, 8'h80, 0, 0, 0, 1, 16'h3CAB));
    // back-to-back with run held high: undefined op then mv R2,#5
    step(1'b1, 1'b1, 16'hE000, mk("nop_t0",     4'd0, 8'h00, 0, 0, 0, 0, 16'h3CAB));
    step(1'b1, 1'b1, 16'h0A05, mk("nop_t1",     4'd0, 8'h00, 0, 0, 0, 1, 16'hE000));
    step(1'b1, 1'b1, 16'h0A05, mk("b2b_t0",     4'd0, 8'h00, 0, 0, 0, 0, 16'hE000));
    step(1'b1, 1'b0, 16'h0000, mk("b2b_mv_t1",  4'd8, 8'h04, 0, 0, 0, 1, 16'h0A05));
    // add R1,R3 aborted by reset in T2; reset falls just after the T2 edge
    step(1'b1, 1'b1, 16'h4403, mk("abort_t0",   4'd0, 8'h00, 0, 0, 0, 0, 16'h0A05));
    step(1'b1, 1'b0, 16'h0000, mk("abort_t1",   4'd1, 8'h00, 1, 0, 0, 0, 16'h4403));
    step(1'b0, 1'b0, 16'h0000, mk("rst_async",  4'd0, 8'h00, 0, 0, 0, 0, 16'h0000));
    step(1'b0, 1'b1, 16'h0A05, mk("rst_hold",   4'd0, 8'h00, 0, 0, 0, 0, 16'h0000));
    step(1'b1, 1'b0, 16'h0000, mk("rst_nodone", 4'd0, 8'h00, 0, 0, 0, 0, 16'h0000));
    // mv R2,R5 after release
    step(1'b1, 1'b1, 16'h0805, mk("post_t0",    4'd0, 8'h00, 0, 0, 0, 0, 16'h0000));
    step(1'b1, 1'b0, 16'h0000, mk("post_mv_t1", 4'd5, 8'h04, 0, 0, 0, 1, 16'h0805));
    step(1'b1, 1'b0, 16'h0000, mk("post_idle",  4'd0, 8'h00, 0, 0, 0, 0, 16'h0805));

    @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
